// File: rtl/trace_buffer.sv
// Retire-trace capture buffer: records committed instructions into a circular
// store under continuous, fill-and-stop or PC-trigger modes, then drains oldest-first.
module trace_buffer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arm,
  input  logic            stop,
  input  logic [1:0]      mode,
  input  logic [XLEN-1:0] trig_pc,
  input  logic [AW-1:0]   post_len,
  input  logic            ret_valid,
  input  logic [XLEN-1:0] ret_pc,
  input  logic [31:0]     ret_instr,
  input  logic [4:0]      ret_rd,
  input  logic [XLEN-1:0] ret_wdata,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [XLEN-1:0] rd_pc,
  output logic [31:0]     rd_instr,
  output logic [4:0]      rd_rd,
  output logic [XLEN-1:0] rd_wdata,
  output logic [AW:0]     count,
  output logic [1:0]      state,
  output logic            overflow,
  output logic            triggered
);

  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    FROZEN  = 2'd3
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
  } entry_t;

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] post_q, post_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          triggered_q, triggered_d;
  logic          wr_en;
  entry_t        mem_q [DEPTH];
  entry_t        rd_entry;

  // Control and pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 2'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      post_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      post_q      <= post_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      triggered_q <= triggered_d;
    end
  end

  // Trace storage carries no reset; contents are only meaningful behind count
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= '{pc: ret_pc, instr: ret_instr, rd: ret_rd, wdata: ret_wdata};
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    post_d      = post_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    triggered_d = triggered_q;
    wr_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d     = CAPTURE;
          mode_d      = (mode == 2'd3) ? 2'd0 : mode;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          post_d      = '0;
          count_d     = '0;
          overflow_d  = 1'b0;
          triggered_d = 1'b0;
        end
      end

      CAPTURE, POST: begin
        if (ret_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (count_q == FULL) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
          if (state_q == CAPTURE) begin
            if (mode_q == 2'd1 && count_q == FULL - CW'(1)) begin
              state_d = FROZEN;
            end
            // post_len is AW bits wide, so it never exceeds DEPTH-1 and the trigger entry survives
            if (mode_q == 2'd2 && !triggered_q && ret_pc == trig_pc) begin
              triggered_d = 1'b1;
              post_d      = post_len;
              state_d     = (post_len == '0) ? FROZEN : POST;
            end
          end else begin
            post_d = post_q - AW'(1);
            if (post_q == AW'(1)) begin
              state_d = FROZEN;
            end
          end
        end
        if (stop) begin
          state_d = FROZEN;
        end
      end

      FROZEN: begin
        if (count_q == '0) begin
          state_d = IDLE;
        end else if (rd_ready) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          count_d  = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rd_valid  = (state_q == FROZEN) && (count_q != '0);
  assign rd_entry  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign rd_pc     = rd_entry.pc;
  assign rd_instr  = rd_entry.instr;
  assign rd_rd     = rd_entry.rd;
  assign rd_wdata  = rd_entry.wdata;
  assign count     = count_q;
  assign state     = state_q;
  assign overflow  = overflow_q;
  assign triggered = triggered_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Scoreboard bench for trace_buffer: a list-based model predicts the surviving
// entries of each capture session; a negedge monitor checks every drained entry.
module tb_trace_buffer;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            arm, stop, ret_valid, rd_ready;
  logic [1:0]      mode;
  logic [XLEN-1:0] trig_pc, ret_pc, ret_wdata;
  logic [AW-1:0]   post_len;
  logic [31:0]     ret_instr;
  logic [4:0]      ret_rd;
  logic            rd_valid, overflow, triggered;
  logic [XLEN-1:0] rd_pc, rd_wdata;
  logic [31:0]     rd_instr;
  logic [4:0]      rd_rd;
  logic [AW:0]     count;
  logic [1:0]      state;

  always #5 clk = ~clk;

  trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .mode(mode),
    .trig_pc(trig_pc), .post_len(post_len),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .ret_rd(ret_rd), .ret_wdata(ret_wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc),
    .rd_instr(rd_instr), .rd_rd(rd_rd), .rd_wdata(rd_wdata),
    .count(count), .state(state), .overflow(overflow), .triggered(triggered)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } ent_t;

  ent_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whatever the read port presents against the scoreboard head
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got entry pc %0h, expected no entry", rd_pc);
        end else begin
          chk("rd_pc",    64'(rd_pc),    64'(exp_q[0].pc));
          chk("rd_instr", 64'(rd_instr), 64'(exp_q[0].instr));
          chk("rd_rd",    64'(rd_rd),    64'(exp_q[0].rd));
          chk("rd_wdata", 64'(rd_wdata), 64'(exp_q[0].wdata));
          if (rd_ready) exp_q.delete(0);
        end
      end else begin
        chk("rd_idle_zero", {rd_pc, rd_instr}, 64'h0);
        chk("rd_idle_zero2", {27'h0, rd_rd, rd_wdata}, 64'h0);
      end
    end
  end

  // One capture session: predict survivors, capture, check flags, then drain
  // (or reset the DUT once count reaches abort_cnt).
  task automatic run_scn(input string tag, input int mode_in, input int n,
                         input logic [31:0] pc_base, input logic [31:0] trig,
                         input int post, input int stop_idx, input int rdy_style,
                         input int abort_cnt);
    ent_t ents[64];
    int   f, t, lo, em, exp_cnt, prev;
    logic exp_ovf, exp_trg, hs;
    bit   done;

    for (int i = 0; i < n; i++) begin
      ents[i].pc    = pc_base + 32'(4 * i);
      ents[i].instr = $urandom;
      ents[i].rd    = 5'($urandom);
      ents[i].wdata = $urandom;
    end

    // Model: the session ends at retire index f; the last DEPTH retires up to f survive
    em = (mode_in == 3) ? 0 : mode_in;
    f  = -1;
    t  = -1;
    if (em == 1 && n >= int'(DEPTH)) f = DEPTH - 1;
    if (em == 2) begin
      for (int i = 0; i < n; i++) if (t < 0 && ents[i].pc == trig) t = i;
      if (t >= 0) begin
        f = t + ((post > int'(DEPTH) - 1) ? int'(DEPTH) - 1 : post);
        if (f > n - 1) f = -1;
      end
    end
    if (stop_idx >= 0 && (f < 0 || stop_idx < f)) f = stop_idx;
    if (f < 0) begin
      $display("FAIL %s/setup: got a session that never freezes, expected a freezing one", tag);
      $fatal(1);
    end
    lo      = (f + 1 > int'(DEPTH)) ? f + 1 - int'(DEPTH) : 0;
    exp_cnt = f - lo + 1;
    exp_ovf = (f + 1 > int'(DEPTH));
    exp_trg = (em == 2) && (t >= 0) && (t <= f);
    for (int i = lo; i <= f; i++) exp_q.push_back(ents[i]);

    // A retire while idle must not be recorded
    ret_valid = 1'b1; ret_pc = 32'hDEAD_0000; tick(); ret_valid = 1'b0;
    chk({tag, "/idle_count"}, 64'(count), 64'h0);
    chk({tag, "/idle_state"}, 64'(state), 64'h0);

    mode = 2'(mode_in); trig_pc = trig; post_len = 4'(post);
    arm = 1'b1; tick(); arm = 1'b0;
    chk({tag, "/armed_state"}, 64'(state), 64'h1);

    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(0, 2);
      repeat (gap) begin ret_valid = 1'b0; stop = 1'b0; tick(); end
      ret_valid = 1'b1;
      ret_pc    = ents[i].pc;
      ret_instr = ents[i].instr;
      ret_rd    = ents[i].rd;
      ret_wdata = ents[i].wdata;
      stop      = (i == stop_idx);
      tick();
      if (state != 2'd3) chk({tag, "/capture_rd_valid"}, 64'(rd_valid), 64'h0);
    end
    ret_valid = 1'b0; stop = 1'b0;

    chk({tag, "/frozen_state"}, 64'(state), 64'h3);
    chk({tag, "/count"}, 64'(count), 64'(exp_cnt));
    chk({tag, "/overflow"}, 64'(overflow), 64'(exp_ovf));
    chk({tag, "/triggered"}, 64'(triggered), 64'(exp_trg));

    arm = 1'b1; tick(); arm = 1'b0;
    chk({tag, "/arm_in_frozen"}, 64'(state), 64'h3);
    chk({tag, "/arm_in_frozen_count"}, 64'(count), 64'(exp_cnt));

    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (abort_cnt >= 0 && int'(count) == abort_cnt) begin
        rd_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk({tag, "/reset_state"}, 64'(state), 64'h0);
        chk({tag, "/reset_count"}, 64'(count), 64'h0);
        chk({tag, "/reset_rd_valid"}, 64'(rd_valid), 64'h0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        return;
      end
      case (rdy_style)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (c % 2 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      prev = int'(count);
      hs   = rd_valid && rd_ready;
      tick();
      chk({tag, "/count_step"}, 64'(count), 64'(prev - int'(hs)));
      if (state == 2'd0) done = 1'b1;
    end
    rd_ready = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s/drain_timeout: got state %0d, expected 0", tag, state);
    end
    chk({tag, "/drain_left"}, 64'(exp_q.size()), 64'h0);
    chk({tag, "/drain_overflow_held"}, 64'(overflow), 64'(exp_ovf));
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected one within the time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arm = 1'b0; stop = 1'b0; mode = 2'd0; trig_pc = '0; post_len = '0;
    ret_valid = 1'b0; ret_pc = '0; ret_instr = '0; ret_rd = '0; ret_wdata = '0;
    rd_ready = 1'b0;
    #1;
    chk("reset_state", 64'(state), 64'h0);
    chk("reset_count", 64'(count), 64'h0);
    chk("reset_rd_valid", 64'(rd_valid), 64'h0);
    chk("reset_flags", {62'h0, overflow, triggered}, 64'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    run_scn("fill",       1, 20, 32'h0,   32'hFFFF_FFF0, 0, -1, 0, -1);
    run_scn("cont",       0, 20, 32'h100, 32'hFFFF_FFF0, 0, 19, 1, -1);
    run_scn("trig_p3",    2, 41, 32'h0,   32'h80,        3, -1, 2, -1);
    run_scn("trig_p15",   2, 50, 32'h0,   32'h80,       15, -1, 1, -1);
    run_scn("trig_p0",    2, 41, 32'h0,   32'h80,        0, -1, 0, -1);
    run_scn("trig_early", 2, 12, 32'h200, 32'h208,       4, -1, 2, -1);
    run_scn("mode3_stop", 3, 10, 32'h300, 32'hFFFF_FFF0, 0,  5, 1, -1);
    run_scn("rst_drain",  1, 16, 32'h400, 32'hFFFF_FFF0, 0, -1, 0,  7);
    tick();
    chk("post_reset_state", 64'(state), 64'h0);

    for (int k = 0; k < 6; k++) begin
      int          m    = $urandom_range(0, 3);
      int          n    = $urandom_range(4, 40);
      int          sidx = $urandom_range(n / 2, n - 1);
      int          pl   = $urandom_range(0, 15);
      logic [31:0] base = 32'h1000 * 32'(k + 1);
      logic [31:0] tp   = (m == 2) ? base + 32'(4 * $urandom_range(0, n - 1)) : 32'hFFFF_FFF0;
      run_scn($sformatf("rand%0d", k), m, n, base, tp, pl, sidx, 2, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
